// File: rtl/data_mem_lsu_if.sv
// Bus bundle between the pipeline MEM stage / data memory (master side) and
// the load/store unit (slave side).
// Default geometry macros: DATA_MEM_ADDR_WIDTH (word address bits) and
// DATA_MEM_SIZE (words); either may be overridden on the command line.
`ifndef DATA_MEM_ADDR_WIDTH
`define DATA_MEM_ADDR_WIDTH 10
`endif
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 1024
`endif

// Handshake: the pipeline raises req_valid with the request fields and holds
// them stable while stall=1. The request is taken on the first edge where the
// LSU is idle and req_valid=1. The pipeline advances on the edge that ends the
// cycle in which stall is low again (the DONE/ERR cycle). ld_valid and
// access_err are single-cycle pulses in that cycle.
interface data_mem_lsu_if;
  logic                            req_valid;
  logic                            req_we;
  logic [1:0]                      req_size;
  logic                            req_unsigned;
  logic [31:0]                     req_addr;
  logic [31:0]                     req_wdata;
  logic                            stall;
  logic                            ld_valid;
  logic [31:0]                     ld_data;
  logic                            access_err;
  logic [`DATA_MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]                     mem_write_data;
  logic                            mem_write_en;
  logic [31:0]                     mem_read_data;
  logic [2:0]                      dbg_state;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  stall, ld_valid, ld_data, access_err,
    input  mem_addr, mem_write_data, mem_write_en, dbg_state
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output stall, ld_valid, ld_data, access_err,
    output mem_addr, mem_write_data, mem_write_en, dbg_state
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit: turns byte-addressed byte/half/word requests into
// word-addressed data_mem accesses. Sub-word stores are read-modify-write,
// loads are sign/zero extended. State is visible on bus.dbg_state.
// Optional feature macro: LSU_BOUNDS_CHECK_EN (out-of-range requests -> ERR).
`ifndef DATA_MEM_ADDR_WIDTH
`define DATA_MEM_ADDR_WIDTH 10
`endif
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 1024
`endif

module data_mem_lsu #(
  parameter int          MEM_RD_LAT = 0,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input logic           clk,
  input logic           rst,
  data_mem_lsu_if.slave bus
);

  localparam int AW         = `DATA_MEM_ADDR_WIDTH;
  localparam bit WAIT_CYCLE = (MEM_RD_LAT != 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_t;

  state_t state_q, state_d;

  // captured request
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  // registered outputs and their next values
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          ld_valid_q, ld_valid_d;
  logic [31:0]   ld_data_q, ld_data_d;
  logic          err_q, err_d;

  logic [31:0] off;
  logic        misaligned;
  logic        oob;
  logic        accept;

  assign off        = bus.req_addr - BASE_ADDR;
  assign misaligned = ((bus.req_size == 2'b01) & off[0]) |
                      (bus.req_size[1] & (off[1:0] != 2'b00));
  assign accept     = (state_q == IDLE) & bus.req_valid;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam logic [29:0] MEM_WORDS = 30'(`DATA_MEM_SIZE);
  assign oob = (off[31:2] >= MEM_WORDS) | (bus.req_addr < BASE_ADDR);
`else
  assign oob = 1'b0;
`endif

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lane, 3'b000});
    h = 16'(w >> {lane[1], 4'b0000});
    case (size)
      2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Insert the right-aligned store data into its lane of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (size)
      2'b00: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = {24'h0, wd[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        data = {16'h0, wd[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wd;
      end
    endcase
    return (w & ~mask) | (data & mask);
  endfunction

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    ld_valid_d  = 1'b0;
    ld_data_d   = 32'h0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (misaligned | oob) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            mem_addr_d = AW'(off >> 2);
            if (bus.req_we & bus.req_size[1]) begin
              state_d     = WRITE;
              mem_we_d    = 1'b1;
              mem_wdata_d = bus.req_wdata;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD, RD_WAIT: begin
        if ((state_q == RD) && WAIT_CYCLE) begin
          state_d = RD_WAIT;
        end else if (we_q) begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = store_merge(bus.mem_read_data, wdata_q, size_q, lane_q);
        end else begin
          state_d    = DONE;
          ld_valid_d = 1'b1;
          ld_data_d  = load_extend(bus.mem_read_data, size_q, lane_q, uns_q);
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      err_q       <= err_d;
    end
  end

  // Private copy of the request so a dropped req_valid cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      lane_q  <= off[1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  assign bus.stall = accept | (state_q == RD) | (state_q == RD_WAIT) |
                     (state_q == WRITE);
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.mem_write_en   = mem_we_q;
  assign bus.ld_valid       = ld_valid_q;
  assign bus.ld_data        = ld_data_q;
  assign bus.access_err     = err_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one instance with a combinational-read
// memory (MEM_RD_LAT=0) and one with a registered-read memory (MEM_RD_LAT=1).
module tb_data_mem_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_lsu_if bus1();
  data_mem_lsu_if bus2();

  logic        rv1, rv2, r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata;

  assign bus1.req_valid    = rv1;
  assign bus1.req_we       = r_we;
  assign bus1.req_size     = r_size;
  assign bus1.req_unsigned = r_uns;
  assign bus1.req_addr     = r_addr;
  assign bus1.req_wdata    = r_wdata;
  assign bus2.req_valid    = rv2;
  assign bus2.req_we       = r_we;
  assign bus2.req_size     = r_size;
  assign bus2.req_unsigned = r_uns;
  assign bus2.req_addr     = r_addr;
  assign bus2.req_wdata    = r_wdata;

  data_mem_lsu #(.MEM_RD_LAT(0), .BASE_ADDR(32'h0)) dut0 (.clk(clk), .rst(rst), .bus(bus1));
  data_mem_lsu #(.MEM_RD_LAT(1), .BASE_ADDR(32'h0)) dut1 (.clk(clk), .rst(rst), .bus(bus2));

  // data memories, reloaded with the preset image while rst is high
  logic [31:0] init_vals [0:9] = '{32'h01, 32'h03, 32'h05, 32'h06, 32'h09,
                                   32'h0c, 32'h0f, 32'h14, 32'h19, 32'h1e};
  logic [31:0] ram1 [0:1023];
  logic [31:0] ram2 [0:1023];
  logic [31:0] rd2;
  int          wr_cnt1 = 0;

  always @(posedge clk) begin
    if (bus1.mem_write_en) begin
      ram1[bus1.mem_addr] <= bus1.mem_write_data;
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram1[i] <= 32'h0;
      for (int i = 0; i < 10; i++) ram1[i] <= init_vals[i];
    end
  end
  assign bus1.mem_read_data = ram1[bus1.mem_addr];

  always @(posedge clk) begin
    rd2 <= ram2[bus2.mem_addr];
    if (bus2.mem_write_en) ram2[bus2.mem_addr] <= bus2.mem_write_data;
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram2[i] <= 32'h0;
      for (int i = 0; i < 10; i++) ram2[i] <= init_vals[i];
    end
  end
  assign bus2.mem_read_data = rd2;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, hold it while stalled, and report what was seen.
  // k = cycles from the accept cycle to the cycle where stall drops.
  task automatic run_req(input logic sel, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         output int k, output int wr_at, output int wr_n,
                         output logic ldv, output logic [31:0] ldd, output logic err,
                         output logic [31:0] wa, output logic [31:0] wdat);
    logic done;
    @(negedge clk);
    r_we = we; r_size = size; r_uns = uns; r_addr = addr; r_wdata = wd;
    if (sel) rv2 = 1'b1; else rv1 = 1'b1;
    k = 0; wr_at = -1; wr_n = 0; done = 1'b0;
    ldv = 1'b0; ldd = 32'h0; err = 1'b0; wa = 32'h0; wdat = 32'h0;
    while (!done && k < 20) begin
      #1;
      if (sel ? bus2.mem_write_en : bus1.mem_write_en) begin
        wr_n++;
        if (wr_at < 0) wr_at = k;
        wa   = 32'(sel ? bus2.mem_addr : bus1.mem_addr);
        wdat = sel ? bus2.mem_write_data : bus1.mem_write_data;
      end
      if (!(sel ? bus2.stall : bus1.stall)) begin
        done = 1'b1;
        ldv  = sel ? bus2.ld_valid : bus1.ld_valid;
        ldd  = sel ? bus2.ld_data : bus1.ld_data;
        err  = sel ? bus2.access_err : bus1.access_err;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    rv1 = 1'b0;
    rv2 = 1'b0;
    check("req_completes", {31'h0, done}, 32'h1);
  endtask

  int          k, wr_at, wr_n, cnt_snap;
  logic        ldv, err;
  logic [31:0] ldd, wa, wdat;

  initial begin
    rst = 1'b1; rv1 = 1'b0; rv2 = 1'b0;
    r_we = 1'b0; r_size = 2'b00; r_uns = 1'b0; r_addr = 32'h0; r_wdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall",    {31'h0, bus1.stall}, 32'h0);
    check("rst_ld_valid", {31'h0, bus1.ld_valid}, 32'h0);
    check("rst_err",      {31'h0, bus1.access_err}, 32'h0);
    check("rst_we",       {31'h0, bus1.mem_write_en}, 32'h0);
    check("rst_addr",     32'(bus1.mem_addr), 32'h0);
    check("rst_wdata",    bus1.mem_write_data, 32'h0);
    check("rst_ld_data",  bus1.ld_data, 32'h0);
    check("rst_state",    32'(bus1.dbg_state), 32'h0);
    check("rst_state2",   32'(bus2.dbg_state), 32'h0);

    // lw 0x08
    run_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lw08_lat", k, 2);
    check("lw08_valid", {31'h0, ldv}, 32'h1);
    check("lw08_data", ldd, 32'h0000_0005);
    check("lw08_nowr", wr_n, 0);
    @(negedge clk); #1;
    check("lw08_pulse", {31'h0, bus1.ld_valid}, 32'h0);

    // sb 0x80 at 0x09, then read back
    run_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_0080, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("sb09_wr_at", wr_at, 2);
    check("sb09_lat", k, 3);
    check("sb09_wr_n", wr_n, 1);
    check("sb09_addr", wa, 32'h2);
    check("sb09_data", wdat, 32'h0000_8005);
    check("sb09_noldv", {31'h0, ldv}, 32'h0);
    check("sb09_ram", ram1[2], 32'h0000_8005);
    run_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h09, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lb09", ldd, 32'hFFFF_FF80);
    run_req(1'b0, 1'b0, 2'b00, 1'b1, 32'h09, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lbu09", ldd, 32'h0000_0080);
    run_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h08, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lh08", ldd, 32'hFFFF_8005);
    run_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h1C, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lb1c", ldd, 32'h0000_0014);

    // sh 0xBEEF at 0x06, then read back
    run_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h06, 32'h1234_BEEF, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("sh06_addr", wa, 32'h1);
    check("sh06_data", wdat, 32'hBEEF_0003);
    check("sh06_ram", ram1[1], 32'hBEEF_0003);
    run_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h06, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lh06", ldd, 32'hFFFF_BEEF);
    run_req(1'b0, 1'b0, 2'b01, 1'b1, 32'h06, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lhu06", ldd, 32'h0000_BEEF);
    run_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lw04", ldd, 32'hBEEF_0003);

    // sw at 0x24, and size 11 store at 0x20
    run_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h24, 32'hDEAD_BEEF, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("sw24_wr_at", wr_at, 1);
    check("sw24_lat", k, 2);
    check("sw24_addr", wa, 32'h9);
    check("sw24_ram", ram1[9], 32'hDEAD_BEEF);
    run_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("s11_wr_at", wr_at, 1);
    check("s11_addr", wa, 32'h8);
    run_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lw20", ldd, 32'h1234_5678);

    // address wrap beyond the memory size
    run_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h1008, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("wrap_err", {31'h0, err}, 32'h0);
    check("wrap_data", ldd, 32'h0000_8005);

    // misaligned requests
    run_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lw06_lat", k, 1);
    check("lw06_err", {31'h0, err}, 32'h1);
    check("lw06_noldv", {31'h0, ldv}, 32'h0);
    check("lw06_ldd", ldd, 32'h0);
    check("lw06_nowr", wr_n, 0);
    run_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFF, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("sh03_lat", k, 1);
    check("sh03_err", {31'h0, err}, 32'h1);
    check("sh03_nowr", wr_n, 0);
    @(negedge clk); #1;
    check("err_pulse", {31'h0, bus1.access_err}, 32'h0);

    // reset during RD of a sub-word store
    @(negedge clk);
    r_we = 1'b1; r_size = 2'b00; r_uns = 1'b0; r_addr = 32'h05; r_wdata = 32'hAA;
    rv1 = 1'b1;
    #1;
    check("rrd_stall", {31'h0, bus1.stall}, 32'h1);
    @(negedge clk); #1;
    check("rrd_in_rd", 32'(bus1.dbg_state), 32'h1);
    cnt_snap = wr_cnt1;
    rst = 1'b1; rv1 = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    check("rrd_state", 32'(bus1.dbg_state), 32'h0);
    check("rrd_stall0", {31'h0, bus1.stall}, 32'h0);
    check("rrd_we", {31'h0, bus1.mem_write_en}, 32'h0);
    check("rrd_addr", 32'(bus1.mem_addr), 32'h0);
    check("rrd_ldv", {31'h0, bus1.ld_valid}, 32'h0);
    check("rrd_errp", {31'h0, bus1.access_err}, 32'h0);
    check("rrd_nowr", wr_cnt1, cnt_snap);
    @(negedge clk); #1;
    check("rrd_nowr2", wr_cnt1, cnt_snap);

    // registered-read memory
    run_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lat1_lw_lat", k, 3);
    check("lat1_lw_valid", {31'h0, ldv}, 32'h1);
    check("lat1_lw_data", ldd, 32'h0000_0005);
    run_req(1'b1, 1'b1, 2'b00, 1'b0, 32'h09, 32'h80, k, wr_at, wr_n, ldv, ldd, err, wa, wdat);
    check("lat1_sb_wr_at", wr_at, 3);
    check("lat1_sb_lat", k, 4);
    check("lat1_sb_data", wdat, 32'h0000_8005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
